// File: rtl/axis_serial_tx.sv
// ---------------------------------------------------------------------------
// axis_serial_tx
//
// Transmit end of the serial link. Bytes arrive on an AXI-Stream slave port.
// Each one goes out on a single registered line as: start bit (1), the data
// bits LSB first, an optional even-parity bit, and a stop bit (0). The first
// word of every packet is preceded by an alternating 1,0,1,0,... preamble so
// the far-end clock-recovery receiver can phase-lock. Every serial bit is
// held for BIT_CYCLES cycles of ref_clk.
//
// Build option:
//   AXIS_SERIAL_TX_PARITY_EN - when defined, an even-parity bit (XOR of the
//                              data bits) is inserted between data and stop.
//
// Parameters:
//   DATA_WIDTH    bits per AXIS beat and per serial word
//   PREAMBLE_LEN  preamble bits per packet (2..255)
//   BIT_CYCLES    ref_clk cycles per serial bit (1..255)
//
// Ports:
//   ref_clk        single clock, rising edge
//   rst_n          asynchronous active-low reset
//   s_axis_tdata   byte to send
//   s_axis_tvalid  source has a beat
//   s_axis_tready  block accepts a beat this cycle
//   s_axis_tlast   beat is the last of its packet
//   data_out       serial line, registered
//   tx_busy        high whenever the block is not idle
// ---------------------------------------------------------------------------
module axis_serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int PREAMBLE_LEN = 8,
  parameter int BIT_CYCLES   = 1
) (
  input  logic                  ref_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic                  data_out,
  output logic                  tx_busy
);

  localparam int IDX_MAX = (PREAMBLE_LEN > DATA_WIDTH) ? PREAMBLE_LEN : DATA_WIDTH;
  localparam int IDX_W   = $clog2(IDX_MAX + 1);
  localparam int CYC_W   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PREAMBLE_LEN - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_SAT   = IDX_W'(IDX_MAX);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    START    = 3'd2,
    DATA     = 3'd3,
`ifdef AXIS_SERIAL_TX_PARITY_EN
    PARITY   = 3'd4,
`endif
    STOP     = 3'd5,
    WAIT     = 3'd6
  } state_t;

  state_t                state, next_state;
  logic [CYC_W-1:0]      cyc_cnt, cyc_next;
  logic [IDX_W-1:0]      idx_cnt, idx_next;
  logic [DATA_WIDTH-1:0] shift_q, shift_next;
  logic                  last_q, last_next;
  logic                  line_next;
  logic                  end_of_bit;
  logic                  transfer;
`ifdef AXIS_SERIAL_TX_PARITY_EN
  logic                  parity_q, parity_next;
`endif

  assign end_of_bit = (cyc_cnt == CYC_LAST);
  assign transfer   = s_axis_tvalid && s_axis_tready;

  // State and datapath registers. data_out is loaded with the value that
  // belongs to the state being entered, so the line lines up with state.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      idx_cnt  <= '0;
      shift_q  <= '0;
      last_q   <= 1'b0;
      data_out <= 1'b0;
`ifdef AXIS_SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= next_state;
      cyc_cnt  <= cyc_next;
      idx_cnt  <= idx_next;
      shift_q  <= shift_next;
      last_q   <= last_next;
      data_out <= line_next;
`ifdef AXIS_SERIAL_TX_PARITY_EN
      parity_q <= parity_next;
`endif
    end
  end

  // Next-state logic. A non-last word's stop bit may chain straight into the
  // next start bit; otherwise an underrun parks in WAIT without re-sending
  // the preamble.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (transfer) next_state = PREAMBLE;
      PREAMBLE: if (end_of_bit && idx_cnt == PRE_LAST) next_state = START;
      START:    if (end_of_bit) next_state = DATA;
      DATA: begin
        if (end_of_bit && idx_cnt == DATA_LAST) begin
`ifdef AXIS_SERIAL_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef AXIS_SERIAL_TX_PARITY_EN
      PARITY:   if (end_of_bit) next_state = STOP;
`endif
      STOP: begin
        if (end_of_bit) begin
          if (last_q)        next_state = IDLE;
          else if (transfer) next_state = START;
          else               next_state = WAIT;
        end
      end
      WAIT:     if (transfer) next_state = START;
      default:  next_state = IDLE;
    endcase
  end

  // Counters restart on every state entry and saturate instead of wrapping.
  // The beat is captured on the transfer edge; the shift register moves one
  // place at the end of each data bit.
  always_comb begin
    cyc_next   = cyc_cnt;
    idx_next   = idx_cnt;
    shift_next = shift_q;
    last_next  = last_q;
    if (next_state != state) begin
      cyc_next = '0;
      idx_next = '0;
    end else if (state != IDLE && state != WAIT) begin
      if (end_of_bit) begin
        cyc_next = '0;
        if (idx_cnt != IDX_SAT) idx_next = idx_cnt + 1'b1;
      end else if (cyc_cnt != CYC_LAST) begin
        cyc_next = cyc_cnt + 1'b1;
      end
    end
    if (transfer) begin
      shift_next = s_axis_tdata;
      last_next  = s_axis_tlast;
    end else if (state == DATA && end_of_bit) begin
      shift_next = shift_q >> 1;
    end
  end

`ifdef AXIS_SERIAL_TX_PARITY_EN
  assign parity_next = transfer ? ^s_axis_tdata : parity_q;
`endif

  // Outputs. tready depends only on state and counters (never on tvalid) and
  // is forced low while reset is held.
  always_comb begin
    s_axis_tready = 1'b0;
    case (state)
      IDLE, WAIT: s_axis_tready = 1'b1;
      STOP:       s_axis_tready = end_of_bit && !last_q;
      default:    s_axis_tready = 1'b0;
    endcase
    s_axis_tready = s_axis_tready && rst_n;

    tx_busy = (state != IDLE);

    // Even preamble indices carry 1, odd ones carry 0.
    line_next = 1'b0;
    case (next_state)
      PREAMBLE: line_next = ~idx_next[0];
      START:    line_next = 1'b1;
      DATA:     line_next = shift_next[0];
`ifdef AXIS_SERIAL_TX_PARITY_EN
      PARITY:   line_next = parity_next;
`endif
      default:  line_next = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_axis_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_axis_serial_tx
//
// Bench for axis_serial_tx. Two instances run side by side: one with one
// ref_clk cycle per bit and one with four. The reference model keeps a
// queue of the line values expected on upcoming cycles; accepting a beat
// appends its whole waveform (preamble when starting a packet, start, data
// LSB first, optional parity, stop), each bit repeated for the bit period.
// ---------------------------------------------------------------------------
module tb_axis_serial_tx;

  localparam int DW = 8;
  localparam int PL = 8;
`ifdef AXIS_SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int WB = DW + 2 + PAR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] tdata;
  logic       tlast;
  logic       tvalid;
  logic       sel;
  logic       valid0, valid1;
  logic       ready0, ready1;
  logic       dout0, dout1;
  logic       busy0, busy1;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int bc    = 1;
  bit q[$];
  bit pkt_open = 1'b0;

  assign valid0 = tvalid && (sel == 1'b0);
  assign valid1 = tvalid && (sel == 1'b1);

  axis_serial_tx #(.DATA_WIDTH(DW), .PREAMBLE_LEN(PL), .BIT_CYCLES(1)) u_dut1 (
    .ref_clk       (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (valid0),
    .s_axis_tready (ready0),
    .s_axis_tlast  (tlast),
    .data_out      (dout0),
    .tx_busy       (busy0)
  );

  axis_serial_tx #(.DATA_WIDTH(DW), .PREAMBLE_LEN(PL), .BIT_CYCLES(4)) u_dut4 (
    .ref_clk       (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (valid1),
    .s_axis_tready (ready1),
    .s_axis_tlast  (tlast),
    .data_out      (dout1),
    .tx_busy       (busy1)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  function automatic bit exp_ready();
    return (rst_n === 1'b1) && (q.size() == 0 || (q.size() == 1 && pkt_open));
  endfunction

  function automatic logic act_dout();
    return sel ? dout1 : dout0;
  endfunction

  function automatic logic act_busy();
    return sel ? busy1 : busy0;
  endfunction

  function automatic logic act_ready();
    return sel ? ready1 : ready0;
  endfunction

  task automatic push_bit(input bit b);
    repeat (bc) q.push_back(b);
  endtask

  // Advance the model by one clock edge.
  task automatic model_edge(input bit xfer);
    bit was_idle;
    if (rst_n !== 1'b1) begin
      q.delete();
      pkt_open = 1'b0;
    end else begin
      was_idle = (q.size() == 0) && !pkt_open;
      if (q.size() != 0) void'(q.pop_front());
      if (xfer) begin
        if (was_idle) for (int i = 0; i < PL; i++) push_bit(i % 2 == 0);
        push_bit(1'b1);
        for (int i = 0; i < DW; i++) push_bit(tdata[i]);
        if (PAR == 1) push_bit(^tdata);
        push_bit(1'b0);
        pkt_open = !tlast;
      end
    end
  endtask

  task automatic compare();
    logic exp_d;
    exp_d = (q.size() != 0) ? q[0] : 1'b0;
    check_output($sformatf("bc%0d_data_out", bc), 32'(act_dout()), 32'(exp_d));
    check_output($sformatf("bc%0d_tx_busy", bc), 32'(act_busy()),
                 32'((q.size() != 0) || pkt_open));
    check_output($sformatf("bc%0d_tready", bc), 32'(act_ready()), 32'(exp_ready()));
    // The instance not under test must stay quiet and idle.
    check_output("idle_data_out", 32'(sel ? dout0 : dout1), 32'(0));
    check_output("idle_tx_busy", 32'(sel ? busy0 : busy1), 32'(0));
    check_output("idle_tready", 32'(sel ? ready0 : ready1), 32'(rst_n === 1'b1));
  endtask

  task automatic tick();
    bit xfer;
    xfer = tvalid && exp_ready();
    @(posedge clk);
    cycle++;
    model_edge(xfer);
    @(negedge clk);
    compare();
  endtask

  // Hold the beat until the model says it was accepted; tvalid stays high.
  task automatic drive_beat(input logic [7:0] d, input bit l);
    bit acc;
    int n;
    n = 0;
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    do begin
      acc = exp_ready();
      tick();
      n++;
    end while (!acc && n < 2000);
    if (!acc) check_output("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || pkt_open) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) check_output("idle_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_not_busy();
    int n;
    n = 0;
    while (act_busy() === 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) check_output("busy_timeout", 32'(0), 32'(1));
  endtask

  task automatic run_suite();
    int t0;
    int n;
    int len;
    int gap;

    // Single-beat packet: preamble + one word, then idle again.
    drive_beat(8'hAA, 1'b1);
    tvalid = 1'b0;
    t0 = cycle;
    wait_not_busy();
    check_output($sformatf("bc%0d_single_len", bc), 32'(cycle - t0), 32'((PL + WB) * bc));
    tick();

    // Back-to-back beats share one preamble.
    drive_beat(8'h0F, 1'b0);
    t0 = cycle;
    drive_beat(8'hF0, 1'b1);
    tvalid = 1'b0;
    wait_not_busy();
    check_output($sformatf("bc%0d_b2b_len", bc), 32'(cycle - t0), 32'((PL + 2 * WB) * bc));

    // Underrun: the packet parks in WAIT, then resumes without a preamble.
    drive_beat(8'h55, 1'b0);
    tvalid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check_output($sformatf("bc%0d_wait_busy", bc), 32'(act_busy()), 32'(1));
    drive_beat(8'h33, 1'b1);
    tvalid = 1'b0;
    t0 = cycle;
    wait_not_busy();
    check_output($sformatf("bc%0d_resume_len", bc), 32'(cycle - t0), 32'(WB * bc));
    wait_idle();

    // Reset in the middle of the data bits (bit 2 of 0x3C is a 1).
    drive_beat(8'h3C, 1'b1);
    tvalid = 1'b0;
    repeat ((PL + 3) * bc) tick();
    #2 rst_n = 1'b0;
    #1;
    check_output($sformatf("bc%0d_rst_data_out", bc), 32'(act_dout()), 32'(0));
    check_output($sformatf("bc%0d_rst_tready", bc), 32'(act_ready()), 32'(0));
    check_output($sformatf("bc%0d_rst_tx_busy", bc), 32'(act_busy()), 32'(0));
    tick();
    tick();
    rst_n = 1'b1;
    drive_beat(8'h96, 1'b1);
    tvalid = 1'b0;
    wait_idle();

    // Random packets with random gaps between beats.
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        gap = $urandom_range(0, 3);
        if (gap != 0) begin
          tvalid = 1'b0;
          repeat (gap) tick();
        end
        drive_beat(8'($urandom_range(0, 255)), b == len - 1);
      end
      tvalid = 1'b0;
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    tick();
  endtask

  initial begin
    rst_n  = 1'b1;
    tvalid = 1'b0;
    tdata  = 8'h00;
    tlast  = 1'b0;
    sel    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_output("reset_data_out0", 32'(dout0), 32'(0));
    check_output("reset_tx_busy0", 32'(busy0), 32'(0));
    check_output("reset_tready0", 32'(ready0), 32'(0));
    check_output("reset_data_out4", 32'(dout1), 32'(0));
    check_output("reset_tx_busy4", 32'(busy1), 32'(0));
    check_output("reset_tready4", 32'(ready1), 32'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check_output("release_tready", 32'(ready0), 32'(1));

    sel = 1'b0;
    bc  = 1;
    run_suite();
    sel = 1'b1;
    bc  = 4;
    run_suite();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got running, want finished (cycle %0d)", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
